systolic_tile_sequencer: RTL
============================

// Module: systolic_tile_sequencer
// PURPOSE
//   Next-generation FSM controller for the NxN systolic array. Accepts matmul commands over a valid/ready
//   handshake and runs K-tiling internally: accumulates k_tiles back-to-back operand tiles without
//   intermediate drains. Supports a runtime result row count, backpressured result readout and abort.
//   Sits between the command decoder and the PE array / skew buffers / activation-to-SRAM writeback path.
// PARAMETERS
//   ARRAY_SIZE   32                              array dimension N
//   MAC_LATENCY  2                               PE multiply-accumulate pipeline depth
//   KT_WIDTH     8                               width of k_tiles field; max 2^KT_WIDTH-1 tiles
//   CNT_WIDTH    $clog2(3*ARRAY_SIZE+MAC_LATENCY)  width of feed/drain/row counters
//   ROW_WIDTH    $clog2(ARRAY_SIZE+1)            width of cmd_rows
// PORTS
//   clk             in   1          clock
//   rst_n           in   1          async active-low reset
//   cmd_valid       in   1          command present
//   cmd_ready       out  1          controller can accept command (==state IDLE)
//   cmd_k_tiles     in   KT_WIDTH   number of K tiles to accumulate; 0 treated as 1
//   cmd_acc_mode    in   1          1 = keep existing accumulator contents (no clear)
//   cmd_rows        in   ROW_WIDTH  result rows to write back; 0 or >N treated as N
//   abort           in   1          synchronous abort, any state
//   busy            out  1          state not IDLE and not DONE
//   done            out  1          1-cycle pulse on normal completion
//   aborted         out  1          1-cycle pulse the cycle after abort is sampled in a non-IDLE state
//   pe_en           out  1          PE enable (LOAD or DRAIN)
//   pe_clear_acc    out  1          CLEAR state and latched acc_mode==0
//   skew_load_en    out  1          LOAD state
//   skew_flush      out  1          CLEAR state
//   tile_start      out  1          first LOAD cycle of each tile (operand fetch address advance)
//   tile_idx        out  KT_WIDTH   current tile, 0..k_tiles-1
//   feed_count      out  CNT_WIDTH  position within tile during LOAD, 0..N-1; else 0
//   row_valid       out  1          RESULT state: drain_row is valid
//   row_ready       in   1          writeback accepts the row
//   drain_row       out  CNT_WIDTH  result row index, 0..rows-1
// BEHAVIOUR
//   Reset: state IDLE; all counters and latched command fields 0; every output 0 except cmd_ready=1.
//   Command fields are latched on cmd_valid&&cmd_ready and are stable for the whole operation.
//   States: IDLE, CLEAR, LOAD, DRAIN, RESULT, DONE.
//   - IDLE->CLEAR on handshake.
//   - CLEAR->LOAD: always exactly 1 cycle, even when acc_mode=1 (skew flush still required).
//   - LOAD: feed_count 0..N-1 per tile.
//       At feed_count==N-1: if tile_idx<k_tiles-1, increment tile_idx, reset feed_count,
//       and stay in LOAD (no bubble); else go to DRAIN.
//   - DRAIN: D = 2*(N-1)+MAC_LATENCY-1 cycles, then RESULT.
//   - RESULT: drain_row advances only on row_valid&&row_ready.
//       Handshake at drain_row==rows-1 -> DONE.
//       row_ready low holds drain_row and the state; no limit on stall length.
//   - DONE: 1 cycle, done=1, then IDLE.
//       A command presented during DONE waits; cmd_ready rises the following cycle.
//   Latency, no stalls: accept at T; CLEAR at T+1; LOAD occupies K*N cycles;
//     then D DRAIN cycles, rows RESULT cycles, 1 DONE cycle.
//   Abort has priority over every transition:
//     - next state IDLE; counters, tile_idx and latched fields cleared;
//     - aborted pulses for 1 cycle; done not asserted.
//     - abort in IDLE, or together with cmd handshake: ignored / command dropped, no aborted pulse.
//   Counters wrap-free by construction: CNT_WIDTH covers N+D; tile_idx never exceeds k_tiles-1.
//   Mid-operation async reset returns to the reset values immediately; no done or aborted pulse.
// STRUCTURE
//   Shared package tpu_ctrl_pkg:
//     - seq_state_t enum (3 bits);
//     - seq_cmd_t struct {k_tiles, acc_mode, rows};
//     - function drain_cycles(N, MAC_LATENCY).
//   One natural sub-module: ctrl_up_counter (param WIDTH; inputs en, clr; output q).
//     Instantiated for feed/drain, tile_idx and drain_row.
// TESTING (N=4, MAC_LATENCY=2 -> D=7)
//   1. k_tiles=1, rows=4, row_ready=1, accept at cycle 0:
//      CLEAR@1, LOAD@2-5, DRAIN@6-12, RESULT rows 0-3 @13-16, done@17, cmd_ready@18.
//   2. k_tiles=3: LOAD@2-13 with no bubble; tile_start@2,6,10; tile_idx 0,1,2; DRAIN@14-20;
//      done@25; pe_clear_acc only @1.
//   3. acc_mode=1: pe_clear_acc stays 0 for the whole run; skew_flush=1 @1; timing as test 1.
//   4. Scenario 1 with row_ready=0 @14-15: drain_row holds 1 @14-16; done slips to 19.
//   5. rows=2: RESULT @13-14, done@15.
//      rows=0 and rows=7: both behave as rows=4.
//   6. abort@8 (in DRAIN): state IDLE@9, aborted@9, pe_en=0@9, no done;
//      a new command accepted @9 runs normally from tile 0.

Source files
------------

// File: rtl/tpu_ctrl_pkg.sv
// Shared control-path types for the systolic array tile sequencer.
//   seq_state_t   : sequencer FSM state (3 bits)
//   seq_cmd_t     : latched matmul command payload
//   drain_cycles  : cycles needed to flush the skewed array plus the MAC pipe
package tpu_ctrl_pkg;

  // Storage widths of the latched command; module parameters must not exceed these.
  localparam int unsigned CMD_KT_W  = 8;
  localparam int unsigned CMD_ROW_W = 8;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_CLEAR  = 3'd1,
    SEQ_LOAD   = 3'd2,
    SEQ_DRAIN  = 3'd3,
    SEQ_RESULT = 3'd4,
    SEQ_DONE   = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic [CMD_KT_W-1:0]  k_tiles;   // already normalised: never 0
    logic                 acc_mode;
    logic [CMD_ROW_W-1:0] rows;      // already normalised: 1..N
  } seq_cmd_t;

  // Last operand needs 2*(N-1) hops across the skewed array, then the MAC pipe.
  function automatic int unsigned drain_cycles(input int unsigned n,
                                               input int unsigned mac_latency);
    return 2 * (n - 1) + mac_latency - 1;
  endfunction

endpackage

// File: rtl/ctrl_up_counter.sv
// Generic clearable up-counter used by the tile sequencer.
//   clk, rst_n : clock, async active-low reset
//   en         : increment by one
//   clr        : synchronous clear, wins over en
//   q          : registered count
module ctrl_up_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/systolic_tile_sequencer.sv
// FSM controller for the NxN systolic array with internal K-tiling.
// Accepts a matmul command, clears (optionally) the accumulators, streams
// k_tiles operand tiles back-to-back, drains the array and hands result rows
// to the writeback path under backpressure. Abort returns to IDLE from anywhere.
//   cmd_*         : command handshake and fields (k_tiles, acc_mode, rows)
//   abort         : synchronous abort
//   busy/done/aborted : status
//   pe_en, pe_clear_acc, skew_load_en, skew_flush : array / skew buffer controls
//   tile_start, tile_idx, feed_count : operand feed position
//   row_valid, row_ready, drain_row  : result row handshake
module systolic_tile_sequencer
  import tpu_ctrl_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE  = 32,
  parameter int unsigned MAC_LATENCY = 2,
  parameter int unsigned KT_WIDTH    = 8,
  parameter int unsigned CNT_WIDTH   = $clog2(3 * ARRAY_SIZE + MAC_LATENCY),
  parameter int unsigned ROW_WIDTH   = $clog2(ARRAY_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [KT_WIDTH-1:0]  cmd_k_tiles,
  input  logic                 cmd_acc_mode,
  input  logic [ROW_WIDTH-1:0] cmd_rows,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 pe_en,
  output logic                 pe_clear_acc,
  output logic                 skew_load_en,
  output logic                 skew_flush,
  output logic                 tile_start,
  output logic [KT_WIDTH-1:0]  tile_idx,
  output logic [CNT_WIDTH-1:0] feed_count,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic [CNT_WIDTH-1:0] drain_row
);

  localparam int unsigned DRAIN_D = drain_cycles(ARRAY_SIZE, MAC_LATENCY);

  seq_state_t state_q, state_d;
  seq_cmd_t   cmd_q, cmd_d;

  logic                 cnt_en, cnt_clr;
  logic                 tile_en, tile_clr;
  logic                 row_en, row_clr;
  logic                 abort_hit;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_next;
  logic [KT_WIDTH-1:0]  tile_q;
  logic [CNT_WIDTH-1:0] row_q;
  logic [KT_WIDTH-1:0]  k_eff;
  logic [ROW_WIDTH-1:0] rows_eff;
  logic                 last_feed, last_drain, last_tile, last_row;

  // Feed position within a tile during LOAD, drain cycle count during DRAIN.
  ctrl_up_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .q     (cnt_q)
  );

  ctrl_up_counter #(.WIDTH(KT_WIDTH)) u_tile (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tile_en),
    .clr   (tile_clr),
    .q     (tile_q)
  );

  ctrl_up_counter #(.WIDTH(CNT_WIDTH)) u_row (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (row_en),
    .clr   (row_clr),
    .q     (row_q)
  );

  // Command normalisation: 0 tiles means 1, 0 or oversize rows means a full array.
  always_comb begin
    k_eff    = (cmd_k_tiles == '0) ? KT_WIDTH'(1) : cmd_k_tiles;
    rows_eff = ((cmd_rows == '0) || (32'(cmd_rows) > ARRAY_SIZE))
               ? ROW_WIDTH'(ARRAY_SIZE) : cmd_rows;
  end

  // Terminal-count decodes; compared at 32 bits so every latched bit participates.
  always_comb begin
    last_feed  = (cnt_q == CNT_WIDTH'(ARRAY_SIZE - 1));
    last_drain = (cnt_q == CNT_WIDTH'(DRAIN_D - 1));
    last_tile  = ((32'(tile_q) + 32'd1) == 32'(cmd_q.k_tiles));
    last_row   = ((32'(row_q) + 32'd1) == 32'(cmd_q.rows));
  end

  // State register and latched command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEQ_IDLE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    tile_en   = 1'b0;
    tile_clr  = 1'b0;
    row_en    = 1'b0;
    row_clr   = 1'b0;
    abort_hit = abort && (state_q != SEQ_IDLE);

    if (abort_hit) begin
      state_d  = SEQ_IDLE;
      cmd_d    = '0;
      cnt_clr  = 1'b1;
      tile_clr = 1'b1;
      row_clr  = 1'b1;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          // Abort coinciding with a handshake drops the command.
          if (cmd_valid && !abort) begin
            state_d        = SEQ_CLEAR;
            cmd_d.k_tiles  = CMD_KT_W'(k_eff);
            cmd_d.acc_mode = cmd_acc_mode;
            cmd_d.rows     = CMD_ROW_W'(rows_eff);
          end
        end
        SEQ_CLEAR: begin
          state_d = SEQ_LOAD;
          cnt_clr = 1'b1;
        end
        SEQ_LOAD: begin
          cnt_en = 1'b1;
          if (last_feed) begin
            cnt_clr = 1'b1;
            if (last_tile) begin
              state_d = SEQ_DRAIN;
            end else begin
              tile_en = 1'b1;
            end
          end
        end
        SEQ_DRAIN: begin
          cnt_en = 1'b1;
          if (last_drain) begin
            cnt_clr = 1'b1;
            state_d = SEQ_RESULT;
          end
        end
        SEQ_RESULT: begin
          if (row_ready) begin
            if (last_row) begin
              row_clr = 1'b1;
              state_d = SEQ_DONE;
            end else begin
              row_en = 1'b1;
            end
          end
        end
        SEQ_DONE: begin
          state_d  = SEQ_IDLE;
          tile_clr = 1'b1;
        end
        default: begin
          state_d  = SEQ_IDLE;
          cmd_d    = '0;
          cnt_clr  = 1'b1;
          tile_clr = 1'b1;
          row_clr  = 1'b1;
        end
      endcase
    end

    if (cnt_clr) begin
      cnt_next = '0;
    end else if (cnt_en) begin
      cnt_next = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_next = cnt_q;
    end
  end

  // Registered controls, decoded from the next state so they align with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      pe_en        <= 1'b0;
      pe_clear_acc <= 1'b0;
      skew_load_en <= 1'b0;
      skew_flush   <= 1'b0;
      tile_start   <= 1'b0;
      feed_count   <= '0;
      row_valid    <= 1'b0;
    end else begin
      cmd_ready    <= (state_d == SEQ_IDLE);
      busy         <= (state_d != SEQ_IDLE) && (state_d != SEQ_DONE);
      done         <= (state_d == SEQ_DONE);
      aborted      <= abort_hit;
      pe_en        <= (state_d == SEQ_LOAD) || (state_d == SEQ_DRAIN);
      pe_clear_acc <= (state_d == SEQ_CLEAR) && !cmd_d.acc_mode;
      skew_load_en <= (state_d == SEQ_LOAD);
      skew_flush   <= (state_d == SEQ_CLEAR);
      tile_start   <= (state_d == SEQ_LOAD) && (cnt_next == '0);
      feed_count   <= (state_d == SEQ_LOAD) ? cnt_next : '0;
      row_valid    <= (state_d == SEQ_RESULT);
    end
  end

  assign tile_idx  = tile_q;
  assign drain_row = row_q;

endmodule
